bus_msg_parser: RTL and testbench

- Upstream stage of the register/BRAM bus chain.
- Consumes received UART bytes and parses ASCII read/write request messages.
- Emits one bus transaction per valid message on the same addr/wdata/rdata/rw/valid bus that bram_core and the other cores take as input.
- Malformed messages are discarded and flagged, so they never reach the bus.

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/hex_decode.sv | 26 ++
 rtl/bus_msg_parser.sv | 171 +++++++++++++++++
 tb/tb_bus_msg_parser.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and ASCII constants for the UART-to-bus bridge chain.
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_TERM = 3'd3,
        ST_DROP = 3'd4
    } parse_state_e;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic is_term(input logic [7:0] code);
        return (code == ASCII_CR) || (code == ASCII_LF);
    endfunction

endpackage

// File: rtl/hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_decode (
    input  logic [7:0] code,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Map an ASCII character to its nibble value and flag legal digits
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if ((code >= 8'h30) && (code <= 8'h39)) begin
            nibble = code[3:0];
            is_hex = 1'b1;
        end else if (((code >= 8'h41) && (code <= 8'h46)) ||
                     ((code >= 8'h61) && (code <= 8'h66))) begin
            // Letters A-F/a-f carry 1..6 in the low nibble
            nibble = code[3:0] + 4'h9;
            is_hex = 1'b1;
        end else begin
            nibble = 4'h0;
            is_hex = 1'b0;
        end
    end

endmodule

// File: rtl/bus_msg_parser.sv
// Parses ASCII "R<addr>" / "W<addr><data>" messages from a UART byte stream
// into single-cycle bus transactions; malformed messages raise error_o.
module bus_msg_parser
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  error_o
);

    localparam int NA    = ADDR_WIDTH / 4;
    localparam int ND    = DATA_WIDTH / 4;
    localparam int NMAX  = (NA > ND) ? NA : ND;
    localparam int CNT_W = $clog2(NMAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(NA - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ND - 1);

    parse_state_e          state_r, state_nx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
    logic [ADDR_WIDTH-1:0] addr_sh_r, addr_nx_s;
    logic [DATA_WIDTH-1:0] data_sh_r, data_nx_s;
    logic                  rw_r, rw_nx_s;
    logic                  fire_s, err_s;
    logic [3:0]            nibble_s;
    logic                  is_hex_s;
    logic                  is_term_s;

    hex_decode u_hex_decode (
        .code   (data_i),
        .nibble (nibble_s),
        .is_hex (is_hex_s)
    );

    assign is_term_s = is_term(data_i);
    assign rdata_o   = {DATA_WIDTH{1'b0}};

    // Parser state, digit counter and shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            addr_sh_r <= {ADDR_WIDTH{1'b0}};
            data_sh_r <= {DATA_WIDTH{1'b0}};
            rw_r      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            addr_sh_r <= addr_nx_s;
            data_sh_r <= data_nx_s;
            rw_r      <= rw_nx_s;
        end
    end

    // Next-state, digit accumulation and transaction/error decisions
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        addr_nx_s  = addr_sh_r;
        data_nx_s  = data_sh_r;
        rw_nx_s    = rw_r;
        fire_s     = 1'b0;
        err_s      = 1'b0;
        if (valid_i) begin
            case (state_r)
                ST_IDLE: begin
                    if ((data_i == ASCII_R) || (data_i == ASCII_W)) begin
                        state_nx_s = ST_ADDR;
                        rw_nx_s    = (data_i == ASCII_W);
                        cnt_nx_s   = {CNT_W{1'b0}};
                        addr_nx_s  = {ADDR_WIDTH{1'b0}};
                        data_nx_s  = {DATA_WIDTH{1'b0}};
                    end else if (is_term_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DROP;
                        err_s      = 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (is_hex_s) begin
                        addr_nx_s = ADDR_WIDTH'({addr_sh_r, nibble_s});
                        if (cnt_r == ADDR_LAST) begin
                            cnt_nx_s   = {CNT_W{1'b0}};
                            state_nx_s = rw_r ? ST_DATA : ST_TERM;
                        end else begin
                            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else if (is_term_s) begin
                        state_nx_s = ST_IDLE;
                        err_s      = 1'b1;
                    end else begin
                        state_nx_s = ST_DROP;
                        err_s      = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (is_hex_s) begin
                        data_nx_s = DATA_WIDTH'({data_sh_r, nibble_s});
                        if (cnt_r == DATA_LAST) begin
                            cnt_nx_s   = {CNT_W{1'b0}};
                            state_nx_s = ST_TERM;
                        end else begin
                            cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else if (is_term_s) begin
                        state_nx_s = ST_IDLE;
                        err_s      = 1'b1;
                    end else begin
                        state_nx_s = ST_DROP;
                        err_s      = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (is_term_s) begin
                        state_nx_s = ST_IDLE;
                        fire_s     = 1'b1;
                    end else begin
                        state_nx_s = ST_DROP;
                        err_s      = 1'b1;
                    end
                end
                ST_DROP: begin
                    if (is_term_s) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_DROP;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Registered bus outputs; address/data hold until the next transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_o  <= {ADDR_WIDTH{1'b0}};
            wdata_o <= {DATA_WIDTH{1'b0}};
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
            error_o <= 1'b0;
        end else begin
            valid_o <= fire_s;
            error_o <= err_s;
            if (fire_s) begin
                addr_o  <= addr_sh_r;
                wdata_o <= rw_r ? data_sh_r : {DATA_WIDTH{1'b0}};
                rw_o    <= rw_r;
            end else begin
                addr_o  <= addr_o;
                wdata_o <= wdata_o;
                rw_o    <= rw_o;
            end
        end
    end

endmodule

// File: tb/tb_bus_msg_parser.sv
// Directed scoreboard bench for bus_msg_parser: expected transactions and
// error pulses are queued per driven byte and matched by a negedge monitor.
module tb_bus_msg_parser;

    logic        clk;
    logic        rst;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [15:0] addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rdata_o;
    logic        rw_o;
    logic        valid_o;
    logic        error_o;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rw;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   cyc;
    int   errors;
    int   checks;

    bus_msg_parser #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_o (rdata_o),
        .rw_o    (rw_o),
        .valid_o (valid_o),
        .error_o (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a byte string; fire_idx/err_idx mark the bytes that must produce a
    // transaction or an error pulse one cycle later (-1 for none).
    task automatic send_msg(input string s, input int fire_idx, input int err_idx,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic rw, input bit gaps);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    valid_i = 1'b0;
                end
            end
            @(negedge clk);
            data_i  = s[i];
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            if (i == fire_idx) begin
                e.cyc = cyc; e.addr = addr; e.wdata = wdata; e.rw = rw;
                exp_q.push_back(e);
            end
            if (i == err_idx) err_q.push_back(cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check({tag, "_pending_txn"}, exp_q.size(), 0);
        check({tag, "_pending_err"}, err_q.size(), 0);
    endtask

    // Monitor: match every output pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   ec;
        if (!rst && valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", cyc, e.cyc);
                check("addr", addr_o, e.addr);
                check("wdata", wdata_o, e.wdata);
                check("rw", rw_o, e.rw);
                check("rdata", rdata_o, 32'd0);
                check("error_with_valid", error_o, 32'd0);
            end
        end
        if (!rst && error_o) begin
            if (err_q.size() == 0) begin
                check("unexpected_error", 32'd1, 32'd0);
            end else begin
                ec = err_q.pop_front();
                check("error_cycle", cyc, ec);
            end
        end
    end

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr", addr_o, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_rw", rw_o, 32'd0);
        check("rst_valid", valid_o, 32'd0);
        check("rst_error", error_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        send_msg("R1234\015", 5, -1, 16'h1234, 16'h0000, 1'b0, 1'b0);
        drain("read1");

        // Back-to-back write then read, trailing LF after CR ignored
        send_msg("WbEeF00a5\n", 9, -1, 16'hBEEF, 16'h00A5, 1'b1, 1'b0);
        send_msg("R0001\015\n", 5, -1, 16'h0001, 16'h0000, 1'b0, 1'b0);
        drain("b2b");

        send_msg("R12G4\015", -1, 3, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_msg("R0002\015", 5, -1, 16'h0002, 16'h0000, 1'b0, 1'b0);
        drain("badhex");

        send_msg("W12\015", -1, 3, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_msg("R1234X\015", -1, 5, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_msg("r1\n", -1, 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        drain("malformed");

        // Reset in the middle of a write message
        send_msg("W00", -1, -1, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_addr", addr_o, 32'd0);
        check("midrst_wdata", wdata_o, 32'd0);
        check("midrst_rw", rw_o, 32'd0);
        check("midrst_valid", valid_o, 32'd0);
        check("midrst_error", error_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_msg("34\015", -1, 0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        send_msg("W0003BEEF\015", 9, -1, 16'h0003, 16'hBEEF, 1'b1, 1'b0);
        drain("midrst");

        send_msg("R00FF\015", 5, -1, 16'h00FF, 16'h0000, 1'b0, 1'b1);
        drain("gaps");
        check("final_rdata", rdata_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
